calculator_key_event: RTL and testbench

Converts one debounced calculator button level into single-cycle key events: press, release, long-press and auto-repeat. It sits directly downstream of the button anti-shake stage, consuming its `button_good` level (updated at most once per 10 ms sample tick), and feeds the calculator's input/digit-entry logic. Holding a digit key therefore yields a first entry on press, then repeated entries after a long-press threshold.

---
 rtl/calculator_key_event.sv | 82 ++++++++
 tb/tb_calculator_key_event.sv | 104 ++++++++++
 2 files changed

// File: rtl/calculator_key_event.sv
// calculator_key_event: turns a debounced button level into press, release,
// long-press and auto-repeat single-cycle events plus a held level.
module calculator_key_event #(
    parameter int ACTIVE_LEVEL  = 1,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter int CNT_W         = 27
) (
    input  logic clk_g,
    input  logic rst,
    input  logic button_good,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);
    typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;
    localparam logic             ACT_LVL  = 1'(ACTIVE_LEVEL);
    localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_CYCLES - 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             act;
    assign act = (button_good == ACT_LVL);
    // armed stays low until the button is seen released, so a key held through reset is ignored
    always_ff @(posedge clk_g) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            armed         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            armed         <= armed | ~act;
            case (state)
                IDLE: if (act && armed) begin
                    state       <= PRESS;
                    press_pulse <= 1'b1;
                    held        <= 1'b1;
                    cnt         <= '0;
                end
                PRESS: if (!act) begin
                    state         <= IDLE;
                    release_pulse <= 1'b1;
                    held          <= 1'b0;
                    cnt           <= '0;
                end else if (cnt == LONG_END) begin
                    state      <= REPEAT;
                    long_pulse <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                REPEAT: if (!act) begin
                    state         <= IDLE;
                    release_pulse <= 1'b1;
                    held          <= 1'b0;
                    cnt           <= '0;
                end else if (cnt == REP_END) begin
                    repeat_pulse <= 1'b1;
                    cnt          <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calculator_key_event.sv
// tb_calculator_key_event: directed vectors with LONG=8, REPEAT=4; outputs are
// checked 1 ns after each rising edge as {press, release, long, repeat, held}.
module tb_calculator_key_event;
    logic clk_g = 1'b0;
    logic rst = 1'b1;
    logic button_good = 1'b0;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    int n_checks = 0;
    int n_fail = 0;

    calculator_key_event #(
        .ACTIVE_LEVEL(1),
        .LONG_CYCLES(8),
        .REPEAT_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .clk_g(clk_g),
        .rst(rst),
        .button_good(button_good),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .held(held)
    );

    always #5 clk_g = ~clk_g;

    typedef struct {
        string      name;
        logic       r;
        logic       b;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic step(input string name, input logic r, input logic b, input logic [4:0] exp);
        logic [4:0] got;
        rst = r;
        button_good = b;
        @(posedge clk_g);
        #1;
        got = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (press,release,long,repeat,held)", name, got, exp);
        end
    endtask

    function automatic void add(input string name, input logic r, input logic b, input logic [4:0] exp);
        vec_t v;
        v.name = name;
        v.r = r;
        v.b = b;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        add("reset", 1, 0, 5'b00000);
        for (int i = 0; i < 3; i++) add("idle", 0, 0, 5'b00000);
        add("short_press", 0, 1, 5'b10001);
        for (int i = 0; i < 4; i++) add("short_held", 0, 1, 5'b00001);
        add("short_release", 0, 0, 5'b01000);
        add("short_after", 0, 0, 5'b00000);
        add("edge_press", 0, 1, 5'b10001);
        for (int i = 0; i < 7; i++) add("edge_held", 0, 1, 5'b00001);
        add("edge_release_not_long", 0, 0, 5'b01000);
        add("edge_after", 0, 0, 5'b00000);
        add("one_cycle_press", 0, 1, 5'b10001);
        add("one_cycle_release", 0, 0, 5'b01000);
        add("one_cycle_after", 0, 0, 5'b00000);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i].name, tbl[i].r, tbl[i].b, tbl[i].exp);

        // long hold: long at k=8, repeats at k=12,16,20
        step("hold_press", 0, 1, 5'b10001);
        for (int k = 1; k <= 20; k++)
            step("hold", 0, 1, {1'b0, 1'b0, k == 8, k > 8 && (k % 4) == 0, 1'b1});
        step("hold_release", 0, 0, 5'b01000);
        step("hold_after", 0, 0, 5'b00000);

        // button held through reset stays ignored until released once
        step("held_thru_reset", 1, 1, 5'b00000);
        for (int i = 0; i < 10; i++) step("unarmed_hold", 0, 1, 5'b00000);
        step("rearm", 0, 0, 5'b00000);
        step("rearm_press", 0, 1, 5'b10001);
        step("rearm_release", 0, 0, 5'b01000);
        step("rearm_after", 0, 0, 5'b00000);

        // reset while in REPEAT: no release, no more repeats
        step("rep_press", 0, 1, 5'b10001);
        for (int k = 1; k <= 9; k++)
            step("rep_hold", 0, 1, {1'b0, 1'b0, k == 8, 1'b0, 1'b1});
        step("rep_reset", 1, 1, 5'b00000);
        for (int i = 0; i < 8; i++) step("post_reset_hold", 0, 1, 5'b00000);
        step("post_reset_release", 0, 0, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
